// File: rtl/md_sched.sv
// Multiply/divide sequencer: owns HI/LO and runs mult/div for a fixed MULT_CYC/DIV_CYC busy window.
// Issue is single-cycle from E. While the resource is busy it requests a D-stage stall instead of accepting new work.
module md_sched #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        md_en,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        IntReq,
  input  logic        eret_E,
  input  logic        md_D,
  output logic        start,
  output logic        busy,
  output logic        stall_req,
  output logic        md_sel,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;   // 0 mult, 1 multu, 2 div, 3 divu
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  logic [3:0]    op_eff;
  logic          iss, is_md;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   a_mag, b_mag, den_s, den_u;
  logic [31:0]   q_mag, r_mag, q_s, r_s, q_u, r_u;

  assign op_eff = (md_op > 4'd8) ? 4'd0 : md_op;
  assign iss    = md_en & ~IntReq & ~eret_E;
  assign is_md  = (op_eff >= 4'd1) && (op_eff <= 4'd4);

  assign start     = iss & is_md & (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign stall_req = md_D & (start | busy);
  assign md_sel    = md_en & ((md_op == 4'd7) | (md_op == 4'd8));
  assign md_out    = (md_op == 4'd7) ? hi_q : (md_op == 4'd8) ? lo_q : 32'd0;
  assign hi        = hi_q;
  assign lo        = lo_q;

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide on magnitudes; a zero divisor is replaced by 1 only to keep the datapath defined.
  assign a_mag = a_q[31] ? -a_q : a_q;
  assign b_mag = b_q[31] ? -b_q : b_q;
  assign den_s = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign den_u = (b_q == 32'd0) ? 32'd1 : b_q;
  assign q_mag = a_mag / den_s;
  assign r_mag = a_mag % den_s;
  assign q_s   = (a_q[31] ^ b_q[31]) ? -q_mag : q_mag;
  assign r_s   = a_q[31] ? -r_mag : r_mag;
  assign q_u   = a_q / den_u;
  assign r_u   = a_q % den_u;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = rs_val;
          b_d     = rt_val;
          op_d    = op_eff[1:0] - 2'd1;
          cnt_d   = (op_eff <= 4'd2) ? CW'(MULT_CYC) : CW'(DIV_CYC);
          state_d = RUN;
        end else if (iss && op_eff == 4'd5) begin
          hi_d = rs_val;
        end else if (iss && op_eff == 4'd6) begin
          lo_d = rs_val;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          case (op_q)
            2'd0: {hi_d, lo_d} = prod_s;
            2'd1: {hi_d, lo_d} = prod_u;
            2'd2: if (b_q != 32'd0) begin
              hi_d = r_s;
              lo_d = q_s;
            end
            default: if (b_q != 32'd0) begin
              hi_d = r_u;
              lo_d = q_u;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: directed scenarios with literal results plus randomized traffic against a behavioural HI/LO model.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        md_en = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        IntReq = 1'b0;
  logic        eret_E = 1'b0;
  logic        md_D = 1'b0;
  logic        start, busy, stall_req, md_sel;
  logic [31:0] md_out, hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  md_sched #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .clr(clr), .md_en(md_en), .md_op(md_op), .rs_val(rs_val), .rt_val(rt_val),
    .IntReq(IntReq), .eret_E(eret_E), .md_D(md_D), .start(start), .busy(busy),
    .stall_req(stall_req), .md_sel(md_sel), .md_out(md_out), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining busy cycles plus the result to deliver when they run out.
  int          m_left = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  logic        p_ok = 1'b0;

  function automatic void model_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic ok, output logic [31:0] rh, output logic [31:0] rl);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ok = 1'b1; rh = 32'd0; rl = 32'd0;
    case (op)
      4'd1: begin p = 64'(sa * sb); rh = p[63:32]; rl = p[31:0]; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0]; end
      4'd3: if (b == 32'd0) ok = 1'b0; else begin
        q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0];
      end
      default: if (b == 32'd0) ok = 1'b0; else begin
        rl = a / b; rh = a % b;
      end
    endcase
  endfunction

  always @(posedge clk or negedge clr) begin
    logic [3:0] op;
    op = (md_op > 4'd8) ? 4'd0 : md_op;
    if (!clr) begin
      m_left = 0; m_hi = 32'd0; m_lo = 32'd0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_ok) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (md_en && !IntReq && !eret_E) begin
      if (op >= 4'd1 && op <= 4'd4) begin
        model_res(op, rs_val, rt_val, p_ok, p_hi, p_lo);
        m_left = (op <= 4'd2) ? 5 : 10;
      end else if (op == 4'd5) m_hi = rs_val;
      else if (op == 4'd6) m_lo = rs_val;
    end
  end

  always @(negedge clk) begin
    logic iss, e_start, e_busy;
    logic [3:0] op;
    op      = (md_op > 4'd8) ? 4'd0 : md_op;
    iss     = md_en && !IntReq && !eret_E;
    e_busy  = (m_left > 0);
    e_start = iss && op >= 4'd1 && op <= 4'd4 && !e_busy;
    check("busy", {31'd0, busy}, {31'd0, e_busy});
    check("start", {31'd0, start}, {31'd0, e_start});
    check("stall_req", {31'd0, stall_req}, {31'd0, md_D && (e_start || e_busy)});
    check("md_sel", {31'd0, md_sel}, {31'd0, md_en && (md_op == 4'd7 || md_op == 4'd8)});
    check("md_out", md_out, (md_op == 4'd7) ? m_hi : (md_op == 4'd8) ? m_lo : 32'd0);
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  end

  // Issue one op for one cycle, then count busy and stall cycles until busy drops; ends at a negedge.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic d,
                        output int nb, output int ns);
    nb = 0; ns = 0;
    @(posedge clk); #1;
    md_en = 1'b1; md_op = op; rs_val = a; rt_val = b; md_D = d;
    @(negedge clk);
    check("issue_start", {31'd0, start}, 32'd1);
    if (stall_req) ns++;
    @(posedge clk); #1;
    md_en = 1'b0; md_op = 4'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stall_req) ns++;
      if (busy) nb++;
      else break;
    end
    md_D = 1'b0;
  endtask

  task automatic one_cycle(input logic [3:0] op, input logic [31:0] a, input logic ir, input logic er);
    @(posedge clk); #1;
    md_en = 1'b1; md_op = op; rs_val = a; IntReq = ir; eret_E = er;
    @(negedge clk);
    check("cancel_start", {31'd0, start}, 32'd0);
    @(posedge clk); #1;
    md_en = 1'b0; md_op = 4'd0; IntReq = 1'b0; eret_E = 1'b0;
    @(negedge clk);
    check("cancel_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int nb, ns;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    #11 clr = 1'b1;

    run_op(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, nb, ns);
    check("mult_busy_cyc", 32'(nb), 32'd5);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);
    check("model_mult_lo", m_lo, 32'hFFFFFFFA);

    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, nb, ns);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);
    check("multu_stall_cyc", 32'(ns), 32'd6);

    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, nb, ns);
    check("div_busy_cyc", 32'(nb), 32'd10);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    run_op(4'd4, 32'd7, 32'd0, 1'b0, nb, ns);
    check("div0_busy_cyc", 32'(nb), 32'd10);
    check("div0_hi", hi, 32'hFFFFFFFF);
    check("div0_lo", lo, 32'hFFFFFFFD);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, nb, ns);
    check("divovf_lo", lo, 32'h80000000);
    check("divovf_hi", hi, 32'h00000000);

    one_cycle(4'd1, 32'd5, 1'b1, 1'b0);
    one_cycle(4'd1, 32'd5, 1'b0, 1'b1);
    one_cycle(4'd6, 32'h1234, 1'b1, 1'b0);
    check("cancel_hi", hi, 32'h00000000);
    check("cancel_lo", lo, 32'h80000000);

    @(posedge clk); #1;
    md_en = 1'b1; md_op = 4'd5; rs_val = 32'hAAAA0000;
    @(posedge clk); #1;
    md_op = 4'd7;
    @(negedge clk);
    check("mfhi_sel", {31'd0, md_sel}, 32'd1);
    check("mfhi_out", md_out, 32'hAAAA0000);
    @(posedge clk); #1;
    md_op = 4'd8; IntReq = 1'b1;
    @(negedge clk);
    check("mflo_sel_int", {31'd0, md_sel}, 32'd1);
    check("mflo_out", md_out, 32'h80000000);
    @(posedge clk); #1;
    md_en = 1'b0; md_op = 4'd0; IntReq = 1'b0;
    run_op(4'd2, 32'h00010000, 32'h00030000, 1'b0, nb, ns);
    #2 md_en = 1'b1; md_op = 4'd7;
    #1 check("mfhi_after_busy", md_out, 32'h00000003);
    @(posedge clk); #1;
    md_en = 1'b0; md_op = 4'd0;

    @(posedge clk); #1;
    md_en = 1'b1; md_op = 4'd3; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    md_en = 1'b0; md_op = 4'd0;
    repeat (3) @(posedge clk);
    #3 clr = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(negedge clk); #1 clr = 1'b1;
    run_op(4'd1, 32'd6, 32'd7, 1'b0, nb, ns);
    check("post_rst_busy_cyc", 32'(nb), 32'd5);
    check("post_rst_lo", lo, 32'd42);

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      md_en  = ($urandom_range(0, 3) != 0);
      md_op  = 4'($urandom_range(0, 15));
      rs_val = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      rt_val = ($urandom_range(0, 5) == 0) ? 32'd0 :
               ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : $urandom;
      IntReq = ($urandom_range(0, 7) == 0);
      eret_E = ($urandom_range(0, 7) == 0);
      md_D   = $urandom_range(0, 1) != 0;
    end
    @(posedge clk); #1;
    md_en = 1'b0; md_op = 4'd0; IntReq = 1'b0; eret_E = 1'b0; md_D = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
